// File: rtl/mipi_capture_ctrl.sv
// Camera frame capture controller: arms on a frame boundary, gates deserializer timing into a capture window,
// counts pixels/lines/frames and flags line, frame and timeout errors. Capture outputs lag inputs by one cycle.
module mipi_capture_ctrl #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  img_clk,
    input  logic                  resetb,
    input  logic                  cap_start,
    input  logic                  cap_stop,
    input  logic                  cap_continuous,
    input  logic [7:0]            num_frames,
    input  logic [15:0]           expected_pixels,
    input  logic [15:0]           expected_lines,
    input  logic [23:0]           timeout_cycles,
    input  logic                  fvo,
    input  logic                  lvo,
    input  logic                  dvo,
    input  logic [DATA_WIDTH-1:0] dato,
    output logic                  des_enable,
    output logic                  cap_fv,
    output logic                  cap_lv,
    output logic                  cap_dv,
    output logic [DATA_WIDTH-1:0] cap_dat,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frames_done,
    output logic [15:0]           last_line_pixels,
    output logic [15:0]           last_frame_lines,
    output logic                  line_err,
    output logic                  frame_err,
    output logic                  timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM     = 3'd1;
    localparam logic [2:0] S_WAIT_FS = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [2:0]            r_state;
    logic                  r_fv_q;
    logic                  r_lv_q;
    logic                  r_win;
    logic                  r_stop_pend;
    logic [23:0]           r_to_cnt;
    logic [15:0]           r_pix_cnt;
    logic [15:0]           r_line_cnt;
    logic [7:0]            r_frames_done;
    logic [15:0]           r_last_line_pixels;
    logic [15:0]           r_last_frame_lines;
    logic                  r_line_err;
    logic                  r_frame_err;
    logic                  r_timeout_err;
    logic                  r_cap_fv;
    logic                  r_cap_lv;
    logic                  r_cap_dv;
    logic [DATA_WIDTH-1:0] r_cap_dat;

    logic                  w_fs;
    logic                  w_fe;
    logic                  w_le;
    logic                  w_win_next;
    logic [23:0]           w_to_inc;
    logic                  w_to_hit;
    logic [15:0]           w_line_inc;
    logic [15:0]           w_lines_at_fe;
    logic [7:0]            w_frames_inc;
    logic [7:0]            w_num_eff;
    logic                  w_more;
    logic                  w_stop_now;

    // Assertion is immediate; release is retimed so every flop leaves reset on the same edge.
    always_ff @(posedge img_clk or negedge resetb) begin
        if (!resetb) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_fs = fvo & ~r_fv_q;
    assign w_fe = ~fvo & r_fv_q;
    assign w_le = ~lvo & r_lv_q;

    // The window opens on the start-of-frame cycle itself so the first timing beat is not lost.
    assign w_win_next = ((r_state == S_WAIT_FS) & w_fs & ~cap_stop)
                      | (r_win & (r_state == S_CAPTURE) & ~w_fe);

    assign w_to_inc      = r_to_cnt + 24'd1;
    assign w_to_hit      = (timeout_cycles != 24'd0) && (w_to_inc == timeout_cycles);
    assign w_line_inc    = (r_line_cnt == 16'hFFFF) ? r_line_cnt : r_line_cnt + 16'd1;
    assign w_lines_at_fe = w_le ? w_line_inc : r_line_cnt;
    assign w_frames_inc  = (r_frames_done == 8'hFF) ? r_frames_done : r_frames_done + 8'd1;
    assign w_num_eff     = (num_frames == 8'd0) ? 8'd1 : num_frames;
    assign w_more        = cap_continuous | (({1'b0, r_frames_done} + 9'd1) < {1'b0, w_num_eff});
    assign w_stop_now    = r_stop_pend | cap_stop;

    always_ff @(posedge img_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state            <= S_IDLE;
            r_fv_q             <= 1'b0;
            r_lv_q             <= 1'b0;
            r_win              <= 1'b0;
            r_stop_pend        <= 1'b0;
            r_to_cnt           <= 24'd0;
            r_pix_cnt          <= 16'd0;
            r_line_cnt         <= 16'd0;
            r_frames_done      <= 8'd0;
            r_last_line_pixels <= 16'd0;
            r_last_frame_lines <= 16'd0;
            r_line_err         <= 1'b0;
            r_frame_err        <= 1'b0;
            r_timeout_err      <= 1'b0;
        end else begin
            r_fv_q <= fvo;
            r_lv_q <= lvo;
            r_win  <= w_win_next;
            case (r_state)
                S_IDLE: begin
                    if (cap_start) begin
                        r_frames_done <= 8'd0;
                        r_line_err    <= 1'b0;
                        r_frame_err   <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_to_cnt      <= 24'd0;
                        r_stop_pend   <= 1'b0;
                        r_state       <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (cap_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_to_hit) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_to_cnt <= w_to_inc;
                        if (!fvo) r_state <= S_WAIT_FS;
                    end
                end
                S_WAIT_FS: begin
                    if (cap_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_fs) begin
                        r_pix_cnt  <= 16'd0;
                        r_line_cnt <= 16'd0;
                        r_to_cnt   <= 24'd0;
                        r_state    <= S_CAPTURE;
                    end else if (w_to_hit) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_CAPTURE: begin
                    if (cap_stop) r_stop_pend <= 1'b1;
                    if (dvo && lvo && r_pix_cnt != 16'hFFFF) r_pix_cnt <= r_pix_cnt + 16'd1;
                    if (w_le) begin
                        r_last_line_pixels <= r_pix_cnt;
                        r_line_cnt         <= w_line_inc;
                        r_pix_cnt          <= 16'd0;
                        if (expected_pixels != 16'd0 && r_pix_cnt != expected_pixels)
                            r_line_err <= 1'b1;
                    end
                    if (w_fe) begin
                        r_last_frame_lines <= w_lines_at_fe;
                        r_frames_done      <= w_frames_inc;
                        if (expected_lines != 16'd0 && w_lines_at_fe != expected_lines)
                            r_frame_err <= 1'b1;
                        r_state <= (w_more && !w_stop_now) ? S_WAIT_FS : S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data only updates on valid beats so downstream sees a stable bus between beats.
    always_ff @(posedge img_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cap_fv  <= 1'b0;
            r_cap_lv  <= 1'b0;
            r_cap_dv  <= 1'b0;
            r_cap_dat <= '0;
        end else begin
            r_cap_fv <= w_win_next & fvo;
            r_cap_lv <= w_win_next & lvo;
            r_cap_dv <= w_win_next & dvo;
            if (w_win_next && dvo) r_cap_dat <= dato;
        end
    end

    assign des_enable       = (r_state == S_ARM) || (r_state == S_WAIT_FS) || (r_state == S_CAPTURE);
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_DONE);
    assign cap_fv           = r_cap_fv;
    assign cap_lv           = r_cap_lv;
    assign cap_dv           = r_cap_dv;
    assign cap_dat          = r_cap_dat;
    assign frames_done      = r_frames_done;
    assign last_line_pixels = r_last_line_pixels;
    assign last_frame_lines = r_last_frame_lines;
    assign line_err         = r_line_err;
    assign frame_err        = r_frame_err;
    assign timeout_err      = r_timeout_err;

endmodule

// File: doc/mipi_capture_ctrl.md
MIPI_CAPTURE_CTRL -- requirements
Module: mipi_capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, meaning width of the pixel data path.
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
 img_clk  in  1  clock; all logic is on its rising edge.
 resetb  in  1  reset: asynchronous, active-low.
 cap_start  in  1  one-cycle pulse that arms a capture.
 cap_stop  in  1  one-cycle pulse that aborts or ends a capture.
 cap_continuous  in  1  1 = capture until stopped.
 num_frames  in  8  frames per capture; 0 is treated as 1.
 expected_pixels  in  16  dvo beats per line; 0 disables the check.
 expected_lines  in  16  lines per frame; 0 disables the check.
 timeout_cycles  in  24  timeout while waiting for a frame; 0 disables.
 fvo, lvo, dvo  in  1 each  frame, line and data valid from the deserializer.
 dato  in  DATA_WIDTH  pixel data from the deserializer.
 des_enable  out  1  enable to the deserializer.
 cap_fv, cap_lv, cap_dv  out  1 each  gated and registered timing.
 cap_dat  out  DATA_WIDTH  registered pixel data.
 busy  out  1  state is not IDLE.
 done  out  1  one-cycle pulse when a capture completes.
 frames_done  out  8  frames completed in the current or last capture.
 last_line_pixels  out  16  pixel count of the most recently completed line.
 last_frame_lines  out  16  line count of the most recently completed frame.
 line_err, frame_err, timeout_err  out  1 each  sticky error flags.

Function
REQ-003 SHALL register fvo and lvo each cycle into fv_q and lv_q, and derive these edge terms:
 fs = fvo & !fv_q
 fe = !fvo & fv_q
 le = !lvo & lv_q
REQ-004 SHALL implement states IDLE, ARM, WAIT_FS, CAPTURE and DONE.
REQ-005 IDLE: des_enable=0; on cap_start SHALL do the following, then go to ARM:
 clear frames_done;
 clear line_err, frame_err and timeout_err;
 clear the timeout counter.
REQ-006 ARM: des_enable=1; SHALL go to WAIT_FS on the first cycle with fvo=0, so a frame already in progress is never captured.
REQ-007 WAIT_FS: des_enable=1; on fs SHALL do the following, then go to CAPTURE:
 set the capture window this cycle;
 clear pix_cnt and line_cnt.
REQ-008 CAPTURE: des_enable=1; SHALL increment pix_cnt on every cycle with dvo&lvo.
REQ-009 On le in CAPTURE SHALL do the following:
 last_line_pixels <= pix_cnt;
 line_cnt increments;
 pix_cnt clears;
 if expected_pixels != 0 and pix_cnt != expected_pixels, line_err is set.
REQ-010 On fe in CAPTURE SHALL do the following:
 last_frame_lines <= line_cnt, where line_cnt includes an le on the same cycle;
 frames_done increments;
 frame_err is set if expected_lines != 0 and the line count differs from it;
 the window clears.
REQ-011 Exit from CAPTURE after fe SHALL be to WAIT_FS when cap_continuous=1, or when frames_done+1 < max(num_frames,1), and no stop is pending; otherwise to DONE.
REQ-012 DONE SHALL last one cycle with des_enable=0 and done=1, then go to IDLE.
REQ-013 cap_fv, cap_lv, cap_dv and cap_dat SHALL be registered copies of fvo, lvo, dvo and dato, with 1-cycle latency.
REQ-014 cap_fv, cap_lv and cap_dv SHALL be forced to 0 whenever the window is clear; cap_dat SHALL hold its value when cap_dv=0.
REQ-015 When fe occurs, cap_fv, cap_lv and cap_dv SHALL be 0 on the following cycle.
REQ-016 Timeout: the counter SHALL increment in ARM and WAIT_FS, and clear on entry to ARM and on fs.
REQ-017 When timeout_cycles != 0 and the counter reaches timeout_cycles, timeout_err SHALL be set, state SHALL go to IDLE, and done SHALL NOT pulse.
REQ-018 cap_stop in ARM or WAIT_FS SHALL return to IDLE next cycle with no done pulse; this takes priority over a simultaneous fs or timeout.
REQ-019 cap_stop in CAPTURE SHALL set stop_pending: the current frame completes, then DONE follows.
REQ-020 cap_stop in IDLE or DONE SHALL be ignored; cap_start when busy=1 SHALL be ignored.
REQ-021 pix_cnt, line_cnt and frames_done SHALL saturate at their maximum and never wrap.
REQ-022 Error flags SHALL be sticky until the next accepted cap_start.

Reset
REQ-023 While resetb=0, all state and outputs SHALL be 0 and state SHALL be IDLE.
REQ-024 Release of resetb SHALL be synchronous to img_clk via a 2-flop synchronizer; reset mid-capture SHALL drop des_enable and all cap_* outputs immediately.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
 Single frame: num_frames=1, 4 lines of 16 dvo, expected_pixels=16, expected_lines=4 -> 64 cap_dv, last_frame_lines=4, frames_done=1, one done pulse, no errors.
 Mid-frame arm: cap_start while fvo=1 -> no cap_fv until fvo falls and rises again; only the next frame passes.
 Continuous stop: cap_continuous=1, cap_stop during frame 3 -> frame 3 completes, frames_done=3, done pulses, des_enable=0.
 Line error: a line of 15 pixels with expected_pixels=16 -> line_err=1, last_line_pixels=15, capture still completes.
 Timeout: timeout_cycles=100, fvo held 0 -> timeout_err=1 and IDLE 100 cycles after ARM, done stays 0.
 Reset mid-line: resetb=0 mid-line -> des_enable and cap_* outputs 0, state IDLE, counters 0.
